grayscale_convert: RTL and testbench
====================================

// Module: grayscale_convert
// PURPOSE
//  Streaming RGB-to-grayscale stage feeding the sobel edge-detect stage.
//  Pops 24-bit RGB pixels from the input FIFO and pushes floor((R+G+B)/3) as 8-bit gray to the output FIFO.
//  The output FIFO is the sobel input FIFO.
//  Two-stage stallable pipeline with raster position counters and an end-of-frame pulse.
// PARAMETERS
//  WIDTH   720  image columns per row
//  HEIGHT  540  image rows per frame
// PORTS
//  clock       in   1   clock, rising edge
//  reset       in   1   reset, asynchronous, active-high
//  in_rd_en    out  1   pop request to input FIFO
//  in_empty    in   1   input FIFO empty
//  in_dout     in   24  input pixel, first-word-fall-through; R=[23:16] G=[15:8] B=[7:0]
//  out_wr_en   out  1   push request to output FIFO
//  out_full    in   1   output FIFO full
//  out_din     out  8   gray pixel, valid when out_wr_en=1
//  frame_done  out  1   1-cycle pulse after last pixel of a frame is pushed
// BEHAVIOUR
//  Reset values: v1=v2=0; sum_q=0; out_din=0; col=row=0; frame_done=0.
//  in_rd_en and out_wr_en are forced to 0 while reset is high.
//  Pipeline valids: v1 (sum stage), v2 (output stage).
//   adv2 = !v2 | !out_full
//   adv1 = !v1 | adv2
//   in_rd_en  = !in_empty & adv1   (combinational)
//   out_wr_en = v2 & !out_full     (combinational)
//  Stage 1: when in_rd_en, sum_q <= R+G+B (10-bit unsigned, max 765) and v1<=1.
//   Otherwise, when adv1, v1<=0. Otherwise hold.
//  Stage 2: when adv2, out_din <= floor(sum_q/3) and v2<=v1. Otherwise hold.
//   floor(sum_q/3) is exact for 0..765, max 255, no saturation needed.
//   A constant-multiply implementation is acceptable: (sum*683)>>11.
//  Latency: pixel popped in cycle N is pushed in cycle N+2 at the earliest.
//   Full throughput is 1 pixel/cycle.
//  Stall: while out_full=1 with v2=1, stage 2 holds, out_din is stable, and no data is lost.
//   Stage 1 also fills and holds, so at most 2 pixels are in flight.
//  Simultaneous pop and push in one cycle is allowed and required for full throughput.
//  in_empty=1 inserts bubbles (v1<=0). The pipeline drains normally.
//  Raster counters advance on each push (out_wr_en=1):
//   col 0..WIDTH-1 wraps to 0 and increments row.
//   At col=WIDTH-1 and row=HEIGHT-1, both wrap to 0 and frame_done<=1 the next cycle.
//  frame_done is registered, high for exactly one cycle; consecutive frames stream back to back.
//  Reset mid-operation: in-flight pixels are discarded, counters clear, and the next frame starts at col=row=0.
//  The FIFOs are reset externally by the same reset.
//  Input bits are unsigned throughout. No X propagation: out_din only updates on adv2.
// STRUCTURE
//  edge_detect_pkg:
//   - IMG_WIDTH=720, IMG_HEIGHT=540
//   - typedef struct packed {logic [7:0] r,g,b;} rgb_t
//   - typedef logic [7:0] gray_t
//   - these are shared with sobel and the image reader/writer stages.
//  One sub-module, div_by_3: combinational 10-bit in -> 8-bit floor quotient.
//   It is reusable and unit-testable exhaustively.
//  Top level holds the pipeline registers, handshake logic and raster counters.
// TESTING
//  1. Push {FF,FF,FF},{00,00,00},{01,01,00},{10,20,30}, out_full=0 -> out_din FF,00,00,20, first push 2 cycles after first pop.
//  2. Exhaustive div_by_3 check over 0..765 -> equals integer floor(sum/3).
//  3. Hold out_full=1 for 10 cycles with a continuous input -> exactly 2 pops, out_din stable; on release, in-order output with no loss or duplication.
//  4. Random in_empty/out_full toggling, 10k pixels -> output stream matches the reference model bit-exactly, in order.
//  5. Stream WIDTH*HEIGHT pixels with WIDTH=4, HEIGHT=3 -> frame_done pulses once, 1 cycle after the 12th push.
//     Next frame pulses after the 24th push.
//  6. Assert reset with 2 pixels in flight -> no out_wr_en during or after reset until new input.
//     Next frame_done only after a full WIDTH*HEIGHT.

Source files
------------

// File: rtl/edge_detect_pkg.sv
// rtl/edge_detect_pkg.sv - shared image geometry and pixel types for the edge-detect chain
package edge_detect_pkg;

    localparam int IMG_WIDTH  = 720;
    localparam int IMG_HEIGHT = 540;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef logic [7:0] gray_t;

    // R+G+B never exceeds 765, so 10 bits hold it exactly
    typedef logic [9:0] rgb_sum_t;

endpackage

// File: rtl/div_by_3.sv
// rtl/div_by_3.sv - combinational floor(x/3) for x in 0..765
module div_by_3
    import edge_detect_pkg::*;
(
    input  rgb_sum_t dividend,
    output gray_t    quotient
);

    // 683/2048 slightly over 1/3; the excess stays below one LSB for x <= 765
    assign quotient = gray_t'((20'(dividend) * 20'd683) >> 11);

endmodule

// File: rtl/grayscale_convert.sv
// rtl/grayscale_convert.sv - two-stage stallable RGB-to-gray stage with raster counters
module grayscale_convert
    import edge_detect_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int HEIGHT = IMG_HEIGHT
) (
    input  logic        clock,
    input  logic        reset,
    output logic        in_rd_en,
    input  logic        in_empty,
    input  logic [23:0] in_dout,
    output logic        out_wr_en,
    input  logic        out_full,
    output logic [7:0]  out_din,
    output logic        frame_done
);

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    rgb_t          pix;
    gray_t         quot;
    logic          adv1;
    logic          adv2;

    logic          v1_q, v1_d;
    logic          v2_q, v2_d;
    rgb_sum_t      sum_q, sum_d;
    gray_t         dout_q, dout_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          frame_done_q, frame_done_d;

    assign pix = in_dout;

    div_by_3 u_div_by_3 (
        .dividend (sum_q),
        .quotient (quot)
    );

    assign adv2      = !v2_q || !out_full;
    assign adv1      = !v1_q || adv2;
    assign in_rd_en  = !reset && !in_empty && adv1;
    assign out_wr_en = !reset && v2_q && !out_full;

    assign out_din    = dout_q;
    assign frame_done = frame_done_q;

    always_comb begin
        sum_d = sum_q;
        v1_d  = v1_q;
        if (in_rd_en) begin
            sum_d = rgb_sum_t'(pix.r) + rgb_sum_t'(pix.g) + rgb_sum_t'(pix.b);
            v1_d  = 1'b1;
        end else if (adv1) begin
            v1_d  = 1'b0;
        end
    end

    always_comb begin
        dout_d = dout_q;
        v2_d   = v2_q;
        if (adv2) begin
            dout_d = quot;
            v2_d   = v1_q;
        end
    end

    // Raster position tracks pushed pixels, not popped ones
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        if (out_wr_en) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            sum_q        <= '0;
            dout_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            sum_q        <= sum_d;
            dout_q       <= dout_d;
            col_q        <= col_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_grayscale_convert.sv
// tb/tb_grayscale_convert.sv - scoreboard bench for grayscale_convert
`timescale 1ns/1ps
module tb_grayscale_convert;
    import edge_detect_pkg::*;

    localparam int W     = 4;
    localparam int H     = 3;
    localparam int FRAME = W * H;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_rd_en;
    logic        in_empty;
    logic [23:0] in_dout;
    logic        out_wr_en;
    logic        out_full;
    logic [7:0]  out_din;
    logic        frame_done;

    rgb_sum_t    div_in;
    gray_t       div_out;

    int checks   = 0;
    int failures = 0;

    logic [23:0] src_q[$];
    int          exp_q[$];
    int          pop_cyc_q[$];
    logic        pop_pending = 1'b0;
    int          cycle = 0;
    int          pops = 0;
    int          pushes = 0;
    int          model_pushes = 0;
    int          fd_expect = -1;
    int          fd_count = 0;
    int          empty_pct = 0;
    int          full_pct = 0;
    logic        force_full = 1'b0;
    logic        strict_lat = 1'b1;

    grayscale_convert #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_rd_en   (in_rd_en),
        .in_empty   (in_empty),
        .in_dout    (in_dout),
        .out_wr_en  (out_wr_en),
        .out_full   (out_full),
        .out_din    (out_din),
        .frame_done (frame_done)
    );

    div_by_3 u_div (
        .dividend (div_in),
        .quotient (div_out)
    );

    always #5 clock = ~clock;

    function automatic int ref_gray(logic [23:0] p);
        return (int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0])) / 3;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Input FIFO model (first-word-fall-through) and output FIFO backpressure
    initial begin
        in_empty = 1'b1;
        in_dout  = '0;
        out_full = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (pop_pending) begin
                if (src_q.size() > 0) src_q.delete(0);
                pop_pending = 1'b0;
            end
            in_empty = (src_q.size() == 0) || (int'($urandom_range(99)) < empty_pct);
            in_dout  = (src_q.size() > 0) ? src_q[0] : 24'($urandom);
            out_full = force_full || (int'($urandom_range(99)) < full_pct);
        end
    end

    // Monitor: record pops into the scoreboard, compare every push
    always @(negedge clock) begin
        if (!reset) begin
            cycle++;
            if (in_rd_en) begin
                exp_q.push_back(ref_gray(in_dout));
                pop_cyc_q.push_back(cycle);
                pops++;
                pop_pending = 1'b1;
            end
            if (out_wr_en) begin
                pushes++;
                check("scoreboard_nonempty", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    int lat;
                    lat = cycle - pop_cyc_q.pop_front();
                    check("out_din", int'(out_din), exp_q.pop_front());
                    if (strict_lat) check("latency", lat, 2);
                    else            check("latency_min", int'(lat >= 2), 1);
                end
                model_pushes++;
                if (model_pushes % FRAME == 0) fd_expect = cycle + 1;
            end
            if (frame_done) fd_count++;
            if (frame_done || cycle == fd_expect)
                check("frame_done", int'(frame_done), int'(cycle == fd_expect));
        end
    end

    task automatic do_reset(int hold);
        @(posedge clock);
        #2;
        reset = 1'b1;
        src_q.delete();
        exp_q.delete();
        pop_cyc_q.delete();
        model_pushes = 0;
        fd_expect    = -1;
        repeat (hold) @(negedge clock);
        check("reset_out_wr_en", int'(out_wr_en), 0);
        check("reset_in_rd_en", int'(in_rd_en), 0);
        check("reset_out_din", int'(out_din), 0);
        check("reset_frame_done", int'(frame_done), 0);
        @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    task automatic wait_drain(int budget);
        int n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        repeat (4) @(negedge clock);
        check("drain", src_q.size() + exp_q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, q0, f0;
        logic [7:0] d0;
        div_in = '0;

        do_reset(3);

        // Directed pixels, free-flowing output
        strict_lat = 1'b1;
        q0 = pushes;
        src_q.push_back(24'hFFFFFF);
        src_q.push_back(24'h000000);
        src_q.push_back(24'h010100);
        src_q.push_back(24'h102030);
        wait_drain(100);
        check("directed_push_count", pushes - q0, 4);

        // Exhaustive divider
        for (int i = 0; i <= 765; i++) begin
            div_in = rgb_sum_t'(i);
            #1;
            check("div_by_3", int'(div_out), i / 3);
        end

        // Output stall with continuous input
        @(negedge clock);
        strict_lat = 1'b0;
        force_full = 1'b1;
        p0 = pops;
        q0 = pushes;
        for (int i = 0; i < 20; i++) src_q.push_back(24'($urandom));
        repeat (4) @(negedge clock);
        #2;
        d0 = out_din;
        repeat (6) @(negedge clock);
        #2;
        check("stall_pops", pops - p0, 2);
        check("stall_pushes", pushes - q0, 0);
        check("stall_out_din_stable", int'(out_din), int'(d0));
        check("stall_head", int'(out_din), (exp_q.size() > 0) ? exp_q[0] : -1);
        force_full = 1'b0;
        wait_drain(200);
        check("stall_release_count", pushes - q0, 20);

        // Random bubbles and backpressure
        empty_pct = 30;
        full_pct  = 30;
        q0 = pushes;
        for (int i = 0; i < 10000; i++) src_q.push_back(24'($urandom));
        wait_drain(60000);
        check("random_push_count", pushes - q0, 10000);
        empty_pct = 0;
        full_pct  = 0;

        // Two back-to-back frames from a clean raster position
        do_reset(2);
        strict_lat = 1'b1;
        f0 = fd_count;
        for (int i = 0; i < 2 * FRAME; i++) src_q.push_back(24'($urandom));
        wait_drain(300);
        check("two_frames_pulses", fd_count - f0, 2);

        // Reset with two pixels held in flight
        @(negedge clock);
        strict_lat = 1'b0;
        force_full = 1'b1;
        for (int i = 0; i < 5; i++) src_q.push_back(24'($urandom));
        repeat (2) src_q.push_back(24'($urandom));
        repeat (6) @(negedge clock);
        check("inflight_before_reset", exp_q.size(), 2);
        q0 = pushes;
        do_reset(3);
        force_full = 1'b0;
        repeat (10) @(negedge clock);
        check("no_push_after_reset", pushes - q0, 0);
        f0 = fd_count;
        for (int i = 0; i < FRAME - 1; i++) src_q.push_back(24'($urandom));
        wait_drain(300);
        check("no_early_frame_done", fd_count - f0, 0);
        src_q.push_back(24'($urandom));
        wait_drain(100);
        check("frame_after_reset", fd_count - f0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
